aer_rate_encoder_rr: RTL and testbench

//   N-channel rate-coded AER encoder for the SNN input layer. Converts multi-bit pixel

---
 rtl/aer_rate_encoder_rr.sv | 126 ++++++++++++
 tb/tb_aer_rate_encoder_rr.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_rate_encoder_rr.sv
// Rate-coded AER encoder: per-channel integrate-and-overflow spike generation with
// round-robin arbitration of pending spikes onto a single valid/ready address bus.
module aer_rate_encoder_rr #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned THRESH      = 256,
  parameter int unsigned DROP_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] pixels,
  output logic [NUM_CH-1:0]             spike_out,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [NUM_CH-1:0]             pending,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int unsigned ACC_W = PIXEL_WIDTH + 1;
  localparam int unsigned SUM_W = PIXEL_WIDTH + 2;
  localparam int unsigned CNT_W = DROP_W + 1;

  logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_CH-1:0]            spike_q, spike_d;
  logic [NUM_CH-1:0]            pending_q, pending_d;
  logic [ADDR_W-1:0]            aer_addr_q, aer_addr_d;
  logic                         aer_valid_q, aer_valid_d;
  logic [ADDR_W-1:0]            last_grant_q, last_grant_d;
  logic [DROP_W-1:0]            drop_q, drop_d;

  logic                         slot_free;
  logic                         grant_vld;
  logic [ADDR_W-1:0]            grant_idx;
  logic [NUM_CH-1:0]            grant_oh;
  logic [NUM_CH-1:0]            rot;
  logic [SUM_W-1:0]             sum;
  logic [CNT_W-1:0]             n_drop;
  logic [CNT_W-1:0]             drop_sum;

  // Arbitration on registered pending, then accumulate/spike/drop accounting.
  always_comb begin
    slot_free    = !aer_valid_q || aer_ready;
    grant_vld    = 1'b0;
    grant_idx    = '0;
    grant_oh     = '0;
    sum          = '0;
    n_drop       = '0;
    acc_d        = acc_q;
    spike_d      = '0;
    pending_d    = pending_q;
    aer_addr_d   = aer_addr_q;
    aer_valid_d  = aer_valid_q;
    last_grant_d = last_grant_q;

    // Rotate so bit 0 is the channel just after the last grant; lowest set bit wins.
    rot = NUM_CH'({pending_q, pending_q} >> (32'(last_grant_q) + 32'd1));
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_vld = 1'b1;
        grant_idx = ADDR_W'((int'(last_grant_q) + 1 + i) % int'(NUM_CH));
      end
    end

    if (slot_free) begin
      if (grant_vld) begin
        grant_oh     = NUM_CH'(1) << grant_idx;
        aer_addr_d   = grant_idx;
        aer_valid_d  = 1'b1;
        last_grant_d = grant_idx;
      end else begin
        aer_valid_d  = 1'b0;
      end
    end
    pending_d = pending_q & ~grant_oh;

    for (int i = 0; i < int'(NUM_CH); i++) begin
      sum      = SUM_W'(acc_q[i]) + SUM_W'(pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
      acc_d[i] = '0;
      if (enable) begin
        if (sum >= SUM_W'(THRESH)) begin
          acc_d[i]     = ACC_W'(sum - SUM_W'(THRESH));
          spike_d[i]   = 1'b1;
          pending_d[i] = 1'b1;
          if (pending_q[i] && !grant_oh[i]) begin
            n_drop = n_drop + CNT_W'(1);
          end
        end else begin
          acc_d[i] = ACC_W'(sum);
        end
      end
    end

    drop_sum = {1'b0, drop_q} + n_drop;
    drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      spike_q      <= '0;
      pending_q    <= '0;
      aer_addr_q   <= '0;
      aer_valid_q  <= 1'b0;
      last_grant_q <= ADDR_W'(NUM_CH - 1);
      drop_q       <= '0;
    end else begin
      acc_q        <= acc_d;
      spike_q      <= spike_d;
      pending_q    <= pending_d;
      aer_addr_q   <= aer_addr_d;
      aer_valid_q  <= aer_valid_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
    end
  end

  assign spike_out  = spike_q;
  assign aer_addr   = aer_addr_q;
  assign aer_valid  = aer_valid_q;
  assign pending    = pending_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_aer_rate_encoder_rr.sv
// Bench for aer_rate_encoder_rr: directed scenarios plus random traffic, each cycle
// compared against an array-based reference of accumulators, pending flags and RR order.
module tb_aer_rate_encoder_rr;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int AW = 2;
  localparam int T  = 256;
  localparam int DW = 16;
  localparam int VW = N + 1 + AW + N + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N*PW-1:0] pixels;
  logic [N-1:0]    spike_out;
  logic [AW-1:0]   aer_addr;
  logic            aer_valid;
  logic            aer_ready;
  logic [N-1:0]    pending;
  logic [DW-1:0]   drop_count;

  aer_rate_encoder_rr #(
    .NUM_CH(N), .PIXEL_WIDTH(PW), .ADDR_W(AW), .THRESH(T), .DROP_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixels(pixels),
    .spike_out(spike_out), .aer_addr(aer_addr), .aer_valid(aer_valid),
    .aer_ready(aer_ready), .pending(pending), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus applied on the next edge
  bit en;
  bit rdy;
  int pix [N];

  // Reference state
  int     m_acc [N];
  bit     m_spike [N];
  bit     m_pend [N];
  bit     m_valid;
  int     m_addr;
  int     m_last;
  longint m_drops;
  int     gen;
  int     dlv;

  logic [VW-1:0] exp_vec;
  logic [VW-1:0] dut_vec;

  task automatic build_exp();
    logic [N-1:0]  es;
    logic [N-1:0]  ep;
    logic [DW-1:0] ed;
    for (int c = 0; c < N; c++) begin
      es[c] = m_spike[c];
      ep[c] = m_pend[c];
    end
    ed = (m_drops > 65535) ? '1 : DW'(m_drops);
    exp_vec = {es, m_valid, AW'(m_addr), ep, ed};
    dut_vec = {spike_out, aer_valid, aer_addr, pending, drop_count};
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_acc[c] = 0; m_spike[c] = 0; m_pend[c] = 0; pix[c] = 0;
    end
    m_valid = 0; m_addr = 0; m_last = N - 1; m_drops = 0;
    gen = 0; dlv = 0; en = 0; rdy = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; aer_ready = 1'b0; pixels = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    build_exp();
  endtask

  // Drive inputs, advance the reference by one edge, then sample #1 after the edge.
  task automatic step();
    bit np [N];
    bit free;
    int g;
    int s;
    enable = en;
    aer_ready = rdy;
    for (int c = 0; c < N; c++) pixels[c*PW +: PW] = PW'(pix[c]);
    if (aer_valid && rdy) dlv++;

    free = !m_valid || rdy;
    g = -1;
    if (free) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    np = m_pend;
    if (g >= 0) begin
      np[g] = 0; m_valid = 1; m_addr = g; m_last = g;
    end else if (free) begin
      m_valid = 0;
    end
    for (int c = 0; c < N; c++) begin
      m_spike[c] = 0;
      if (!en) begin
        m_acc[c] = 0;
      end else begin
        s = m_acc[c] + pix[c];
        if (s >= T) begin
          m_acc[c] = s - T;
          m_spike[c] = 1;
          gen++;
          if (m_pend[c] && c != g) m_drops++;
          np[c] = 1;
        end else begin
          m_acc[c] = s;
        end
      end
    end
    m_pend = np;
    @(posedge clk);
    #1;
    build_exp();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", dut_vec);
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    en = 1; rdy = 1; pix[0] = 128;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cyc == 1 || cyc == 2) begin
        total++;
        if (spike_out !== ((cyc == 2) ? 4'b0001 : 4'b0000)) begin
          bad++;
          $display("FAIL single_spike_edge cyc=%0d got=%b", cyc, spike_out);
        end
      end
      if (cyc == 3) begin
        total++;
        if ({aer_valid, aer_addr} !== 3'b100) begin
          bad++;
          $display("FAIL single_first_event got=%b exp=100", {aer_valid, aer_addr});
        end
      end
    end
    total++;
    if (drop_count !== '0) begin
      bad++;
      $display("FAIL single_drops got=%0d exp=0", drop_count);
    end
  endtask

  task automatic test_all_max();
    do_reset();
    en = 1; rdy = 1;
    for (int c = 0; c < N; c++) pix[c] = 255;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      step();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL allmax_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cyc >= 3) begin
        total++;
        if ({aer_valid, aer_addr} !== {1'b1, AW'((cyc - 3) % N)}) begin
          bad++;
          $display("FAIL allmax_rr cyc=%0d got=%b exp=1_%0d", cyc, {aer_valid, aer_addr}, (cyc - 3) % N);
        end
      end
    end
    total++;
    if (drop_count == '0 || gen !== dlv + int'(drop_count) + $countones(pending) + int'(aer_valid)) begin
      bad++;
      $display("FAIL allmax_scoreboard gen=%0d dlv=%0d drop=%0d pend=%b valid=%b",
               gen, dlv, drop_count, pending, aer_valid);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d0;
    do_reset();
    en = 1; rdy = 0; pix[2] = 255;
    d0 = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 21) rdy = 1;
      step();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL stall_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cyc >= 3 && cyc <= 20) begin
        total++;
        if ({aer_valid, aer_addr, pending[2]} !== 4'b1101) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got=%b exp=1101", cyc, {aer_valid, aer_addr, pending[2]});
        end
      end
      if (cyc == 20) d0 = drop_count;
    end
    total++;
    if (d0 < DW'(15)) begin
      bad++;
      $display("FAIL stall_drops got=%0d exp>=15", d0);
    end
  endtask

  task automatic test_zero();
    do_reset();
    en = 1; rdy = 1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      step();
      total++;
      if ({spike_out, aer_valid, drop_count} !== '0) begin
        bad++;
        $display("FAIL zero_quiet cyc=%0d got=%h", cyc, {spike_out, aer_valid, drop_count});
      end
    end
  endtask

  task automatic test_disable_drain();
    do_reset();
    en = 1; rdy = 1; pix[1] = 128; pix[3] = 128;
    step(); step();
    en = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      step();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL disable_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cyc <= 3) begin
        total++;
        if ({aer_valid, aer_addr} !== ((cyc == 1) ? 3'b101 : (cyc == 2) ? 3'b111 : 3'b011)) begin
          bad++;
          $display("FAIL disable_drain cyc=%0d got=%b", cyc, {aer_valid, aer_addr});
        end
      end
    end
    en = 1; pix[3] = 0;
    step();
    step();
    total++;
    if (spike_out !== 4'b0010) begin
      bad++;
      $display("FAIL disable_acc_cleared got=%b exp=0010", spike_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1; rdy = 0; pix[2] = 255;
    repeat (4) step();
    total++;
    if (aer_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup got=%b exp=1", aer_valid);
    end
    rst_n = 1'b0;
    #1;
    build_exp();
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL midrst_async got=%h exp=0", dut_vec);
    end
    do_reset();
    en = 1; rdy = 1;
    for (int c = 0; c < N; c++) pix[c] = 255;
    repeat (3) step();
    total++;
    if ({aer_valid, aer_addr} !== 3'b100 || dut_vec !== exp_vec) begin
      bad++;
      $display("FAIL midrst_first_grant got=%h exp=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < N; c++) pix[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      end
      step();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    total++;
    if (gen !== dlv + int'(drop_count) + $countones(pending) + int'(aer_valid)) begin
      bad++;
      $display("FAIL random_scoreboard gen=%0d dlv=%0d drop=%0d pend=%b valid=%b",
               gen, dlv, drop_count, pending, aer_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_all_max();
    test_stall();
    test_zero();
    test_disable_drain();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
